// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   NOP_INSTR        - canonical RISC-V NOP (addi x0,x0,0) placed in IF/ID when empty
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
//   fetch_state_t    - fetch FSM states
//   align_pc()       - forces a target address to word alignment
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous active-high reset.
//   clk    in  clock
//   reset  in  synchronous reset, clears count
//   en     in  increment enable
//   count  out current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, issues one outstanding
// request at a time to instruction memory, loads the IF/ID register, buffers a
// response that arrives during a stall, and drains stale responses on redirect.
// Optional feature macro: FETCH_PERF_EN enables the bubble_cycles counter.
//   clk, reset           clock, synchronous active-high reset
//   stall                hold IF/ID and PC
//   redirect_valid/_pc   EX-stage taken branch/jump and its target
//   imem_req_valid/_ready/imem_addr   request channel
//   imem_rsp_valid/_data               response channel (in order, one per request)
//   if_id_pc/_instr/_valid             IF/ID pipeline register
//   bubble_cycles        count of unstalled bubble loads (0 without FETCH_PERF_EN)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic [31:0] bubble_cycles
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_hold_pc;
    logic [31:0]  r_hold_instr;
    logic [31:0]  r_ifid_pc;
    logic [31:0]  r_ifid_instr;
    logic         r_ifid_valid;

    logic [31:0]  w_pc_plus4;
    logic [31:0]  w_redirect_pc;
    logic         w_deliver;
    logic         w_release;
    logic         w_load;
    logic [31:0]  w_load_pc;
    logic [31:0]  w_load_instr;
    logic         w_accept;

    always_comb begin
        w_pc_plus4    = r_pc + 32'd4;
        w_redirect_pc = align_pc(redirect_pc);
        w_deliver     = (r_state == ST_WAIT) && imem_rsp_valid && !stall && !redirect_valid;
        w_release     = (r_state == ST_HOLD) && !stall && !redirect_valid;
        w_load        = w_deliver || w_release;
        w_load_pc     = w_release ? r_hold_pc    : r_pc;
        w_load_instr  = w_release ? r_hold_instr : imem_rsp_data;
        // A delivering WAIT cycle issues the next request straight away at pc+4,
        // which is what keeps zero-wait memory at one instruction per cycle.
        imem_req_valid = (r_state == ST_REQ) || w_deliver;
        imem_addr      = (r_state == ST_WAIT) ? w_pc_plus4 : r_pc;
        w_accept       = imem_req_valid && imem_req_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_REQ;
            r_pc         <= RESET_PC;
            r_hold_pc    <= '0;
            r_hold_instr <= NOP_INSTR;
        end else begin
            unique case (r_state)
                ST_REQ: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redirect_pc;
                        // A request accepted this cycle is now stale.
                        r_state <= w_accept ? ST_DRAIN : ST_REQ;
                    end else if (w_accept) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redirect_pc;
                        // Without the response in hand it is still in flight.
                        r_state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
                    end else if (imem_rsp_valid) begin
                        if (stall) begin
                            r_hold_pc    <= r_pc;
                            r_hold_instr <= imem_rsp_data;
                            r_state      <= ST_HOLD;
                        end else begin
                            r_pc    <= w_pc_plus4;
                            r_state <= w_accept ? ST_WAIT : ST_REQ;
                        end
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= ST_REQ;
                    end else if (!stall) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (redirect_valid) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (imem_rsp_valid) begin
                        r_state <= ST_REQ;
                    end
                end
                default: r_state <= ST_REQ;
            endcase
        end
    end

    // IF/ID priority: redirect flush > stall hold > load > bubble.
    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end else if (stall) begin
            r_ifid_pc    <= r_ifid_pc;
            r_ifid_instr <= r_ifid_instr;
            r_ifid_valid <= r_ifid_valid;
        end else if (w_load) begin
            r_ifid_pc    <= w_load_pc;
            r_ifid_instr <= w_load_instr;
            r_ifid_valid <= 1'b1;
        end else begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_valid <= 1'b0;
        end
    end

    assign if_id_pc    = r_ifid_pc;
    assign if_id_instr = r_ifid_instr;
    assign if_id_valid = r_ifid_valid;

`ifdef FETCH_PERF_EN
    logic        w_bubble;
    logic [31:0] w_bubble_cnt;

    assign w_bubble = !redirect_valid && !stall && !w_load;

    sat_counter #(
        .WIDTH(32)
    ) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_bubble),
        .count (w_bubble_cnt)
    );

    assign bubble_cycles = w_bubble_cnt;
`else
    assign bubble_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage. A memory model answers
// each accepted request with its own address as data after a set latency;
// directed scenarios push the expected IF/ID loads, and a monitor pops and
// compares them as the DUT presents new instructions.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic [31:0] bubble_cycles;

    logic        d2_req_valid;
    logic [31:0] d2_addr;
    logic [31:0] d2_if_id_pc;
    logic [31:0] d2_if_id_instr;
    logic        d2_if_id_valid;
    logic [31:0] d2_bubble_cycles;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_PERF_EN
    localparam logic [31:0] EXP_BUB_S1 = 32'd1;
    localparam logic [31:0] EXP_BUB_S5 = 32'd21;
`else
    localparam logic [31:0] EXP_BUB_S1 = 32'd0;
    localparam logic [31:0] EXP_BUB_S5 = 32'd0;
`endif

    fetch_stage u_dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid),
        .bubble_cycles  (bubble_cycles)
    );

    // Second instance in lockstep, only used to observe PC wrap from the top word.
    fetch_stage #(
        .RESET_PC(32'hFFFF_FFFC)
    ) u_dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (d2_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (d2_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_pc       (d2_if_id_pc),
        .if_id_instr    (d2_if_id_instr),
        .if_id_valid    (d2_if_id_valid),
        .bubble_cycles  (d2_bubble_cycles)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int t0 = 0;
    int lat = 1;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    task automatic push_exp(input int c, input logic [31:0] p, input logic [31:0] i);
        exp_t e;
        e.cyc = c;
        e.pc = p;
        e.instr = i;
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp_v, cyc - t0);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; cycle k is relative to reset release.
    task automatic goto_cycle(input int k);
        while ((cyc - t0) < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int latency);
        @(posedge clk);
        #1;
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        lat = latency;
        sb.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        t0 = cyc;
    endtask

    // Memory model: one outstanding request, response = request address.
    logic        m_pending = 1'b0;
    logic [31:0] m_addr = '0;
    int          m_due = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset && m_pending && (cyc == m_due)) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = m_addr;
                m_pending = 1'b0;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (reset) begin
                m_pending = 1'b0;
            end else if (imem_req_valid && imem_req_ready) begin
                m_pending = 1'b1;
                m_addr = imem_addr;
                m_due = cyc + lat;
            end
        end
    end

    // Monitor: a valid IF/ID after an unstalled cycle is a new load; after a
    // stalled cycle it must still hold the last instruction.
    logic        prev_stall = 1'b0;
    logic [31:0] last_pc = '0;
    logic [31:0] last_instr = NOP;
    initial begin
        exp_t e;
        int rel;
        forever begin
            @(negedge clk);
            rel = cyc - t0;
            if (if_id_valid && !prev_stall) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL ifid_unexpected: got pc=%h instr=%h at cycle %0d, required no load",
                             if_id_pc, if_id_instr, rel);
                end else begin
                    e = sb.pop_front();
                    if (if_id_pc !== e.pc || if_id_instr !== e.instr || rel != e.cyc) begin
                        n_err++;
                        $display("FAIL ifid_load: got pc=%h instr=%h cycle %0d, required pc=%h instr=%h cycle %0d",
                                 if_id_pc, if_id_instr, rel, e.pc, e.instr, e.cyc);
                    end
                    last_pc = e.pc;
                    last_instr = e.instr;
                end
            end else if (if_id_valid && prev_stall) begin
                chk("ifid_hold_pc", if_id_pc, last_pc);
                chk("ifid_hold_instr", if_id_instr, last_instr);
            end
            prev_stall = stall;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: zero-wait memory, four back-to-back fetches, reset values, PC wrap.
        do_reset(1);
        push_exp(2, 32'h0, 32'h0);
        push_exp(3, 32'h4, 32'h4);
        push_exp(4, 32'h8, 32'h8);
        push_exp(5, 32'hC, 32'hC);
        @(negedge clk);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ifid_valid", 32'(if_id_valid), 32'd0);
        chk("rst_ifid_instr", if_id_instr, NOP);
        chk("rst_ifid_pc", if_id_pc, 32'h0);
        chk("rst_bubble", bubble_cycles, 32'h0);
        chk("wrap_addr0", d2_addr, 32'hFFFF_FFFC);
        goto_cycle(1);
        @(negedge clk);
        chk("wrap_addr1", d2_addr, 32'h0000_0000);
        chk("wrap_req_valid1", 32'(d2_req_valid), 32'd1);
        goto_cycle(2);
        @(negedge clk);
        chk("wrap_ifid_pc", d2_if_id_pc, 32'hFFFF_FFFC);
        chk("wrap_ifid_instr", d2_if_id_instr, 32'h0);
        chk("wrap_ifid_valid", 32'(d2_if_id_valid), 32'd1);
        goto_cycle(4);
        imem_req_ready = 1'b0;
        goto_cycle(5);
        @(negedge clk);
        chk("s1_bubble", bubble_cycles, EXP_BUB_S1);
        chk("wrap_bubble", d2_bubble_cycles, EXP_BUB_S1);
        goto_cycle(6);
        @(negedge clk);
        chk("s1_next_addr", imem_addr, 32'h10);
        goto_cycle(9);
        chk("s1_sb_empty", 32'(sb.size()), 32'd0);

        // 2: stall for 3 cycles while the response for pc 4 arrives.
        do_reset(1);
        push_exp(2, 32'h0, 32'h0);
        push_exp(6, 32'h4, 32'h4);
        push_exp(8, 32'h8, 32'h8);
        goto_cycle(2);
        stall = 1'b1;
        @(negedge clk);
        chk("s2_hold_no_req", 32'(imem_req_valid), 32'd0);
        goto_cycle(5);
        stall = 1'b0;
        goto_cycle(7);
        imem_req_ready = 1'b0;
        goto_cycle(11);
        chk("s2_sb_empty", 32'(sb.size()), 32'd0);

        // 3: redirect in WAIT, stale response 4 cycles later is drained.
        do_reset(4);
        push_exp(10, 32'h100, 32'h100);
        goto_cycle(1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        goto_cycle(2);
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        chk("s3_flush_valid", 32'(if_id_valid), 32'd0);
        chk("s3_drain_no_req", 32'(imem_req_valid), 32'd0);
        goto_cycle(5);
        @(negedge clk);
        chk("s3_target_req", 32'(imem_req_valid), 32'd1);
        chk("s3_target_addr", imem_addr, 32'h100);
        goto_cycle(6);
        imem_req_ready = 1'b0;
        goto_cycle(13);
        chk("s3_sb_empty", 32'(sb.size()), 32'd0);

        // 4: stall and redirect together, unaligned target.
        do_reset(1);
        push_exp(2, 32'h0, 32'h0);
        push_exp(5, 32'h200, 32'h200);
        goto_cycle(2);
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        goto_cycle(3);
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        @(negedge clk);
        chk("s4_flush_valid", 32'(if_id_valid), 32'd0);
        chk("s4_flush_instr", if_id_instr, NOP);
        chk("s4_flush_pc", if_id_pc, 32'h0);
        chk("s4_target_addr", imem_addr, 32'h200);
        goto_cycle(4);
        imem_req_ready = 1'b0;
        goto_cycle(8);
        chk("s4_sb_empty", 32'(sb.size()), 32'd0);

        // 5: 3-cycle memory over 10 instructions: 1 REQ bubble + 2 per instruction.
        do_reset(3);
        for (int k = 0; k < 10; k++) begin
            push_exp(4 + 3 * k, 32'(4 * k), 32'(4 * k));
        end
        goto_cycle(28);
        imem_req_ready = 1'b0;
        goto_cycle(31);
        @(negedge clk);
        chk("s5_bubble", bubble_cycles, EXP_BUB_S5);
        goto_cycle(34);
        chk("s5_sb_empty", 32'(sb.size()), 32'd0);

        // Reset clears the counter.
        do_reset(1);
        @(negedge clk);
        chk("rst2_bubble", bubble_cycles, 32'h0);
        chk("rst2_ifid_valid", 32'(if_id_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined RISC-V core: owns the PC, issues requests to instruction memory over a valid/ready request channel, and loads the IF/ID pipeline register consumed by decode and the load-use hazard logic. Honours the hazard unit's stall by holding IF/ID and buffering an in-flight response. On a branch/jump redirect from EX it flushes IF/ID and discards stale memory responses.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; 1 = hold IF/ID contents and PC
- redirect_valid  in  1  EX-stage taken branch/jump
- redirect_pc  in  32  target PC for redirect
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  32  fetch address (word aligned)
- imem_rsp_valid  in  1  response data valid (exactly one per accepted request, in order)
- imem_rsp_data  in  32  instruction word
- if_id_pc  out  32  PC of instruction in IF/ID
- if_id_instr  out  32  instruction in IF/ID (NOP 32'h0000_0013 when invalid)
- if_id_valid  out  1  IF/ID holds a real instruction
- bubble_cycles  out  32  fetch-starvation counter (see Configuration)

## Operation
- At most one outstanding memory request. `deliver` = response usable this cycle and stall=0 and redirect_valid=0.
- States: REQ, WAIT, HOLD, DRAIN.
- REQ: imem_req_valid=1, imem_addr=pc. Accepted → WAIT. Redirect without accept → pc<=redirect_pc, stay REQ (address may change only on redirect). Redirect with accept → pc<=redirect_pc, DRAIN.
- WAIT: on imem_rsp_valid: deliver → IF/ID<={pc, data, 1}, pc<=pc+4, and same cycle imem_req_valid=1 with imem_addr=pc+4 (combinational); accepted → stay WAIT, else → REQ. If stall=1 → capture {pc,data} in hold buffer, → HOLD. If redirect → discard, pc<=redirect_pc, → REQ.
- HOLD: imem_req_valid=0. stall=0 → move buffer to IF/ID, pc<=pc+4, → REQ. Redirect → discard buffer, pc<=redirect_pc, → REQ.
- DRAIN: imem_req_valid=0; wait imem_rsp_valid, discard, → REQ. Redirect in DRAIN → update pc, stay DRAIN.
- IF/ID update priority: redirect (flush: valid=0, instr=NOP, pc=0) > stall (hold) > deliver (load) > bubble (valid=0, instr=NOP).
- PC arithmetic modulo 2^32; pc+4 wraps 32'hFFFF_FFFC → 0. redirect_pc[1:0] ignored (forced 0).

## Timing
- Reset: state REQ, pc=RESET_PC, imem_req_valid=1 in first cycle after reset, if_id_valid=0, if_id_instr=NOP, if_id_pc=0, bubble_cycles=0.
- Reset mid-transaction: any outstanding response arriving after reset is not tracked; memory must be reset together with this block.
- Zero-wait memory (ready=1, response cycle after accept): steady-state one instruction per cycle; first instruction in IF/ID 2 cycles after reset release.
- Redirect at cycle n: IF/ID invalid at n+1; new target request issued at n+1 (from REQ) or after drain.
- stall and redirect together: redirect wins.

## Configuration
- FETCH_PERF_EN defined: bubble_cycles increments (saturating at 32'hFFFF_FFFF) each cycle IF/ID loads a bubble with stall=0 and redirect_valid=0; cleared by reset.
- Undefined: counter logic absent, bubble_cycles tied to 0.

## Structure
- Shared package fetch_pkg: NOP constant 32'h0000_0013, fetch state enum (REQ/WAIT/HOLD/DRAIN), default reset PC.
- Sub-module sat_counter (32-bit saturating, sync reset, enable) instantiated only under FETCH_PERF_EN; FSM, PC and hold buffer stay in fetch_stage.

## Test plan
- Reset, ready=1, 1-cycle memory returning addr-as-data → IF/ID shows pc 0,4,8,12 on consecutive cycles from cycle 2, if_id_instr==if_id_pc.
- stall=1 for 3 cycles while response arrives → IF/ID holds prior instr; after stall drops, held instruction appears next cycle, no instruction lost or duplicated.
- Redirect to 32'h0000_0100 while in WAIT, response arrives 4 cycles later → response discarded, next IF/ID instruction has pc 0x100, if_id_valid=0 meanwhile.
- Redirect and stall asserted same cycle → IF/ID flushed (valid=0, NOP), fetch resumes at target.
- RESET_PC=32'hFFFF_FFFC → second fetch address 32'h0000_0000.
- With FETCH_PERF_EN, memory with 3-cycle response latency over 10 instructions → bubble_cycles=20+initial bubbles; without macro → stays 0.
